// File: rtl/instr_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the RV32I datapath.
// Drives IR load, PC increment and register-file write strobes.
module instr_controller #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [6:0]           opcode,
  output logic                 ir_wren,
  output logic                 pc_inc,
  output logic                 regfile_wren,
  output logic                 mem_wren,
  output logic                 illegal,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] EXECUTE = 3'd3;
  localparam logic [2:0] TRAP    = 3'd4;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  logic [3:0] wait_cnt;
  logic       fetch_done;
  logic       is_alu;
  logic       is_fence;

  assign fetch_done = (state == FETCH) && (wait_cnt == LAT);
  assign is_alu     = (opcode == OP_OP) || (opcode == OP_OP_IMM);
  assign is_fence   = (opcode == OP_FENCE);

  // Outputs depend only on registered state, never on opcode.
  always_comb begin
    ir_wren      = fetch_done;
    pc_inc       = fetch_done;
    regfile_wren = (state == EXECUTE);
    mem_wren     = 1'b0;
    illegal      = (state == TRAP);
    busy         = (state != IDLE) && (state != TRAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      retired  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 4'd0;
          if (run)
            state <= FETCH;
        end
        FETCH: begin
          if (fetch_done) begin
            state    <= DECODE;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DECODE: begin
          unique case (1'b1)
            is_alu: state <= EXECUTE;
            is_fence: begin
              retired  <= retired + 1'b1;
              wait_cnt <= 4'd0;
              state    <= run ? FETCH : IDLE;
            end
            default: state <= TRAP;
          endcase
        end
        EXECUTE: begin
          retired  <= retired + 1'b1;
          wait_cnt <= 4'd0;
          state    <= run ? FETCH : IDLE;
        end
        TRAP: state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  a_no_ir_rf: assert property (
    @(posedge clk) disable iff (!rst)
    !(ir_wren && regfile_wren));

  a_pc_ir: assert property (
    @(posedge clk) disable iff (!rst)
    pc_inc == ir_wren);

  a_pc_once: assert property (
    @(posedge clk) disable iff (!rst)
    pc_inc |=> !pc_inc);

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller: three instances cover
// default, long memory latency and a narrow retire counter.
module tb_instr_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [6:0] opcode = 7'd0;

  logic        ir_a, pc_a, rf_a, mw_a, il_a, bz_a;
  logic [2:0]  st_a;
  logic [31:0] rt_a;
  logic        ir_b, pc_b, rf_b, mw_b, il_b, bz_b;
  logic [2:0]  st_b;
  logic [31:0] rt_b;
  logic        ir_c, pc_c, rf_c, mw_c, il_c, bz_c;
  logic [2:0]  st_c;
  logic [3:0]  rt_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_controller u_dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .ir_wren(ir_a), .pc_inc(pc_a), .regfile_wren(rf_a),
    .mem_wren(mw_a), .illegal(il_a), .busy(bz_a),
    .state(st_a), .retired(rt_a)
  );

  instr_controller #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .ir_wren(ir_b), .pc_inc(pc_b), .regfile_wren(rf_b),
    .mem_wren(mw_b), .illegal(il_b), .busy(bz_b),
    .state(st_b), .retired(rt_b)
  );

  instr_controller #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .ir_wren(ir_c), .pc_inc(pc_c), .regfile_wren(rf_c),
    .mem_wren(mw_c), .illegal(il_c), .busy(bz_c),
    .state(st_c), .retired(rt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] op);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    opcode = op;
    run = 1'b1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    start(7'b0110011);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({st_a, ir_a, pc_a, rf_a, mw_a, il_a, bz_a} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_outs: got st=%0d ir=%b pc=%b rf=%b mw=%b il=%b bz=%b want all 0",
               st_a, ir_a, pc_a, rf_a, mw_a, il_a, bz_a);
    end
    n_cmp++;
    if (rt_a !== 32'd0) begin
      n_err++;
      $display("FAIL reset_retired: got %0d want 0", rt_a);
    end
  endtask

  task automatic test_op_ml1();
    logic [2:0] exp_st;
    start(7'b0110011);
    for (int i = 0; i < 12; i++) begin
      tick();
      case (i % 4)
        0, 1: exp_st = 3'd1;
        2: exp_st = 3'd2;
        default: exp_st = 3'd3;
      endcase
      n_cmp++;
      if (st_a !== exp_st || ir_a !== (i % 4 == 1) || pc_a !== (i % 4 == 1)
          || rf_a !== (i % 4 == 3) || bz_a !== 1'b1 || mw_a !== 1'b0) begin
        n_err++;
        $display("FAIL op_ml1 cyc%0d: got st=%0d ir=%b pc=%b rf=%b bz=%b mw=%b want st=%0d",
                 i, st_a, ir_a, pc_a, rf_a, bz_a, mw_a, exp_st);
      end
      n_cmp++;
      if (rt_a !== 32'(i / 4)) begin
        n_err++;
        $display("FAIL op_ml1_ret cyc%0d: got %0d want %0d", i, rt_a, i / 4);
      end
    end
    tick();
    n_cmp++;
    if (rt_a !== 32'd3 || st_a !== 3'd1) begin
      n_err++;
      $display("FAIL op_ml1_end: got ret=%0d st=%0d want ret=3 st=1", rt_a, st_a);
    end
  endtask

  task automatic test_op_imm_ml3();
    logic [2:0] exp_st;
    start(7'b0010011);
    for (int i = 0; i < 12; i++) begin
      tick();
      case (i % 6)
        0, 1, 2, 3: exp_st = 3'd1;
        4: exp_st = 3'd2;
        default: exp_st = 3'd3;
      endcase
      n_cmp++;
      if (st_b !== exp_st || ir_b !== (i % 6 == 3) || pc_b !== (i % 6 == 3)
          || rf_b !== (i % 6 == 5)) begin
        n_err++;
        $display("FAIL ml3 cyc%0d: got st=%0d ir=%b pc=%b rf=%b want st=%0d",
                 i, st_b, ir_b, pc_b, rf_b, exp_st);
      end
      n_cmp++;
      if (rt_b !== 32'(i / 6)) begin
        n_err++;
        $display("FAIL ml3_ret cyc%0d: got %0d want %0d", i, rt_b, i / 6);
      end
    end
  endtask

  task automatic test_fence();
    logic rf_seen;
    start(7'b0110011);
    for (int i = 0; i < 4; i++) tick();
    opcode = 7'b0001111;
    rf_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rf_a) rf_seen = 1'b1;
    end
    n_cmp++;
    if (rf_seen !== 1'b0) begin
      n_err++;
      $display("FAIL fence_rf: got regfile_wren pulse want none");
    end
    n_cmp++;
    if (rt_a !== 32'd2 || st_a !== 3'd1) begin
      n_err++;
      $display("FAIL fence_ret: got ret=%0d st=%0d want ret=2 st=1", rt_a, st_a);
    end
  endtask

  task automatic test_trap();
    start(7'b1101111);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (st_a !== 3'd4 || il_a !== 1'b1 || bz_a !== 1'b0) begin
      n_err++;
      $display("FAIL trap_enter: got st=%0d il=%b bz=%b want st=4 il=1 bz=0",
               st_a, il_a, bz_a);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (st_a !== 3'd4 || il_a !== 1'b1 || rt_a !== 32'd0
          || {ir_a, pc_a, rf_a, mw_a} !== 4'd0) begin
        n_err++;
        $display("FAIL trap_hold cyc%0d: got st=%0d il=%b ret=%0d strobes=%b%b%b%b",
                 i, st_a, il_a, rt_a, ir_a, pc_a, rf_a, mw_a);
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (st_a !== 3'd0 || il_a !== 1'b0) begin
      n_err++;
      $display("FAIL trap_reset: got st=%0d il=%b want st=0 il=0", st_a, il_a);
    end
  endtask

  task automatic test_halt();
    start(7'b0110011);
    tick();
    run = 1'b0;
    tick();
    n_cmp++;
    if (st_a !== 3'd1 || ir_a !== 1'b1) begin
      n_err++;
      $display("FAIL halt_fetch: got st=%0d ir=%b want st=1 ir=1", st_a, ir_a);
    end
    tick();
    tick();
    n_cmp++;
    if (st_a !== 3'd3 || rf_a !== 1'b1) begin
      n_err++;
      $display("FAIL halt_exec: got st=%0d rf=%b want st=3 rf=1", st_a, rf_a);
    end
    tick();
    n_cmp++;
    if (st_a !== 3'd0 || rt_a !== 32'd1 || bz_a !== 1'b0) begin
      n_err++;
      $display("FAIL halt_idle: got st=%0d ret=%0d bz=%b want st=0 ret=1 bz=0",
               st_a, rt_a, bz_a);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (st_a !== 3'd0 || rt_a !== 32'd1) begin
      n_err++;
      $display("FAIL halt_stay: got st=%0d ret=%0d want st=0 ret=1", st_a, rt_a);
    end
    run = 1'b1;
    tick();
    n_cmp++;
    if (st_a !== 3'd1) begin
      n_err++;
      $display("FAIL halt_resume: got st=%0d want 1", st_a);
    end
  endtask

  task automatic test_wrap();
    start(7'b0110011);
    for (int i = 1; i <= 69; i++) begin
      tick();
      if (i == 61) begin
        n_cmp++;
        if (rt_c !== 4'd15) begin
          n_err++;
          $display("FAIL wrap_15: got %0d want 15", rt_c);
        end
      end
      if (i == 65) begin
        n_cmp++;
        if (rt_c !== 4'd0) begin
          n_err++;
          $display("FAIL wrap_0: got %0d want 0", rt_c);
        end
      end
    end
    n_cmp++;
    if (rt_c !== 4'd1) begin
      n_err++;
      $display("FAIL wrap_end: got %0d want 1", rt_c);
    end
  endtask

  initial begin
    test_reset();
    test_op_ml1();
    test_op_imm_ml3();
    test_fence();
    test_trap();
    test_halt();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
